// File: rtl/uart_pkt_parser_if.sv
// uart_pkt_parser_if: RX FIFO pop side and payload stream side of the UART packet parser
interface uart_pkt_parser_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       read_uart;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;

    modport master (
        input  rx_empty, r_data, m_ready,
        output read_uart, m_data, m_valid, m_last, pkt_done, pkt_err, err_code
    );

    modport slave (
        output rx_empty, r_data, m_ready,
        input  read_uart, m_data, m_valid, m_last, pkt_done, pkt_err, err_code
    );
endinterface

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: SYNC/LEN/payload[/checksum] frames from a FWFT UART RX FIFO to a ready/valid byte stream; define UART_PKT_CSUM_EN for the trailing checksum byte
module uart_pkt_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 1000
) (
    input logic               clk,
    input logic               reset,
    uart_pkt_parser_if.master bus
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;

    state_t        state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          pop;
    logic          accept;

    assign accept = valid_q & bus.m_ready;

    // Frame FSM: pop decision, payload register, checksum, inter-byte timeout and status pulses
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        csum_d  = csum_q;
        data_d  = data_q;
        valid_d = accept ? 1'b0 : valid_q;
        last_d  = accept ? 1'b0 : last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        pop     = 1'b0;
        tmo_d   = (state_q == HUNT) ? '0 : tmo_q + TW'(bus.rx_empty);
        case (state_q)
            HUNT: begin
`ifdef UART_PKT_CSUM_EN
                pop = ~bus.rx_empty;
`else
                // the previous frame's last byte must be accepted (and pkt_done raised) before a new frame starts
                pop = ~bus.rx_empty & ~(valid_q & last_q);
`endif
                if (pop && bus.r_data == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
                pop = ~bus.rx_empty;
                if (pop) begin
                    rem_d  = bus.r_data;
                    csum_d = bus.r_data;
                    if (bus.r_data == 8'd0 || bus.r_data > LEN_MAX) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = HUNT;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                pop = ~bus.rx_empty & (~valid_q | bus.m_ready);
                if (pop) begin
                    data_d  = bus.r_data;
                    valid_d = 1'b1;
                    last_d  = rem_q == 8'd1;
                    rem_d   = rem_q - 8'd1;
                    csum_d  = csum_q + bus.r_data;
`ifdef UART_PKT_CSUM_EN
                    if (rem_q == 8'd1) state_d = CSUM;
`else
                    if (rem_q == 8'd1) state_d = HUNT;
`endif
                end
            end
`ifdef UART_PKT_CSUM_EN
            CSUM: begin
                pop = ~bus.rx_empty;
                if (pop) begin
                    done_d  = bus.r_data == csum_q;
                    err_d   = bus.r_data != csum_q;
                    code_d  = (bus.r_data == csum_q) ? code_q : 2'b10;
                    state_d = HUNT;
                end
            end
`endif
            default: state_d = HUNT;
        endcase
        if (pop) begin
            tmo_d = '0;
        end else if (state_q != HUNT && bus.rx_empty && tmo_q == TMO_LAST) begin
            tmo_d   = '0;
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = HUNT;
        end
`ifndef UART_PKT_CSUM_EN
        done_d = accept & last_q;
`endif
    end

    // State and output registers; reset drops any frame in progress without reporting it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            rem_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.read_uart = pop & ~reset;
    assign bus.m_data    = data_q;
    assign bus.m_valid   = valid_q;
    assign bus.m_last    = last_q;
    assign bus.pkt_done  = done_q;
    assign bus.pkt_err   = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: doc/uart_pkt_parser.md
UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, meaning the largest legal payload length in bytes (1..255).
REQ-003 The block SHALL have parameter TIMEOUT, default 1000, meaning the inter-byte timeout in clk cycles inside a frame.
REQ-004 Port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port rx_empty, input, 1 bit: UART RX FIFO empty flag.
REQ-007 Port r_data, input, 8 bits: UART RX FIFO head byte, valid whenever rx_empty=0 (first-word fall-through).
REQ-008 Port read_uart, output, 1 bit: one-cycle pop strobe to the UART RX FIFO.
REQ-009 Port m_data, output, 8 bits: payload byte to the downstream sink.
REQ-010 Port m_valid, output, 1 bit: m_data holds a payload byte.
REQ-011 Port m_ready, input, 1 bit: the sink accepts m_data this cycle when m_valid=1.
REQ-012 Port m_last, output, 1 bit: m_data is the final payload byte of the frame.
REQ-013 Port pkt_done, output, 1 bit: one-cycle pulse on clean frame completion.
REQ-014 Port pkt_err, output, 1 bit: one-cycle pulse on frame abort.
REQ-015 Port err_code, output, 2 bits: cause of the latest pkt_err; 01 bad length, 10 checksum, 11 timeout; held until the next pkt_err.

Function
REQ-016 The FSM SHALL have states HUNT, LEN, PAYLOAD, CSUM.
REQ-017 read_uart SHALL be asserted only when rx_empty=0, and never for more than one cycle per byte.
REQ-018 In HUNT, each available byte SHALL be popped; SYNC_BYTE moves to LEN, any other value is discarded and the FSM stays in HUNT.
REQ-019 In LEN, the popped byte SHALL be loaded into the remaining-byte counter and seed the 8-bit checksum; a value of 0 or >MAX_LEN pulses pkt_err with err_code=01 and returns to HUNT; otherwise the FSM moves to PAYLOAD.
REQ-020 In PAYLOAD, a byte SHALL be popped only when rx_empty=0 and (m_valid=0 or m_ready=1), and registered onto m_data with m_valid=1 on the next cycle (latency 1 cycle from pop).
REQ-021 m_valid and m_data SHALL hold stable until m_ready=1; simultaneous accept and pop reloads the register with no bubble.
REQ-022 m_last SHALL be 1 exactly with the byte for which the remaining-byte counter reaches 0; the FSM then leaves PAYLOAD.
REQ-023 The checksum SHALL be the modulo-256 sum of the length byte and all payload bytes.
REQ-024 In CSUM, the popped byte SHALL be compared to the checksum; equal pulses pkt_done, unequal pulses pkt_err with err_code=10; both return to HUNT.
REQ-025 The timeout counter SHALL clear on every pop and in HUNT, and count cycles with rx_empty=1 in LEN, PAYLOAD or CSUM; reaching TIMEOUT pulses pkt_err with err_code=11 and returns to HUNT.
REQ-026 A payload byte already in the m_data register at abort SHALL still be delivered; m_last is not asserted for an aborted frame unless already set.
REQ-027 pkt_done and pkt_err SHALL never be asserted in the same cycle.

Reset
REQ-028 On reset=1, asynchronously: state=HUNT, read_uart=0, m_valid=0, m_data=0, m_last=0, pkt_done=0, pkt_err=0, err_code=00, counters and checksum=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame without a pkt_err pulse.

Configuration
REQ-030 With macro UART_PKT_CSUM_EN defined, the CSUM state and checksum check SHALL be present as above.
REQ-031 Without UART_PKT_CSUM_EN, no checksum byte is expected; pkt_done SHALL pulse the cycle after the m_last byte is accepted by the sink, and err_code=10 never occurs.

Verification
REQ-032 Bytes 00,A5,03,11,22,33,69 with m_ready=1 -> m_data 11,22,33 with m_last on 33, pkt_done one pulse, 00 dropped.
REQ-033 Same frame with checksum byte 6A -> payload delivered, pkt_err pulse, err_code=10.
REQ-034 A5,00 then A5,11 (MAX_LEN=16) -> two pkt_err pulses, err_code=01, no m_valid.
REQ-035 A5,02,AA then FIFO empty for TIMEOUT cycles -> AA delivered, pkt_err, err_code=11, FSM in HUNT.
REQ-036 Frame A5,02,01,02,03 with m_ready held 0 for 10 cycles -> m_data=01 stable, read_uart deasserted until release; reset mid-payload -> all outputs 0, no pkt_err.
